// File: rtl/micro_cook_ctrl.sv
// Microwave cook-cycle controller.
// Captures a 4-digit BCD MM:SS set time from the keypad, then counts elapsed time up
// in BCD once per second and finishes when elapsed equals the set time. Handles the
// door interlock (pause/resume), stop/clear and an end-of-cook beep.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   key_valid  one-cycle strobe qualifying key_digit
//   key_digit  BCD keypad digit (values above 9 are ignored)
//   start      start/resume request (level)
//   stop       stop/clear request (level)
//   door_open  door interlock, 1 = open
//   mag_on     magnetron enable
//   lamp_on    cavity lamp
//   beep       beeper enable
//   busy       high while cooking or paused
//   disp       {min_tens, min_units, sec_tens, sec_units} BCD
module micro_cook_ctrl #(
  parameter int unsigned TICK_DIV     = 100000000,
  parameter int unsigned BEEP_SECONDS = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_digit,
  input  logic        start,
  input  logic        stop,
  input  logic        door_open,
  output logic        mag_on,
  output logic        lamp_on,
  output logic        beep,
  output logic        busy,
  output logic [15:0] disp
);

  localparam int unsigned PsW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned BcW = (BEEP_SECONDS > 1) ? $clog2(BEEP_SECONDS) : 1;

  typedef enum logic [2:0] {StIdle, StEntry, StCook, StPause, StDone} state_e;

  state_e           state_q, state_d;
  logic [15:0]      set_q, set_d;
  logic [15:0]      el_q, el_d;
  logic [PsW-1:0]   ps_q, ps_d;
  logic [BcW-1:0]   bc_q, bc_d;

  logic             tick;
  logic             start_ok;
  logic [15:0]      el_inc;

  // MM:SS increment; minute tens wraps 9->0 (not reachable from a valid set time).
  function automatic logic [15:0] bcd_inc(input logic [15:0] t);
    logic [15:0] r;
    r = t;
    if (t[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      if (t[7:4] == 4'd5) begin
        r[7:4] = 4'd0;
        if (t[11:8] == 4'd9) begin
          r[11:8]  = 4'd0;
          r[15:12] = (t[15:12] == 4'd9) ? 4'd0 : t[15:12] + 4'd1;
        end else begin
          r[11:8] = t[11:8] + 4'd1;
        end
      end else begin
        r[7:4] = t[7:4] + 4'd1;
      end
    end else begin
      r[3:0] = t[3:0] + 4'd1;
    end
    return r;
  endfunction

  assign tick     = (ps_q == PsW'(TICK_DIV - 1));
  assign el_inc   = bcd_inc(el_q);
  assign start_ok = (set_q != 16'h0000) && (set_q[7:4] <= 4'd5) && !door_open;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      set_q   <= 16'h0000;
      el_q    <= 16'h0000;
      ps_q    <= '0;
      bc_q    <= '0;
    end else begin
      state_q <= state_d;
      set_q   <= set_d;
      el_q    <= el_d;
      ps_q    <= ps_d;
      bc_q    <= bc_d;
    end
  end

  // Priority inside each state: stop > door_open > tick > start > key_valid.
  always_comb begin
    state_d = state_q;
    set_d   = set_q;
    el_d    = el_q;
    ps_d    = ps_q;
    bc_d    = bc_q;
    unique case (state_q)
      StIdle, StEntry: begin
        if (stop) begin
          set_d   = 16'h0000;
          state_d = StIdle;
        end else if (start) begin
          // A rejected start also swallows any coincident key press.
          if (start_ok) begin
            el_d    = 16'h0000;
            ps_d    = '0;
            state_d = StCook;
          end
        end else if (key_valid && (key_digit <= 4'd9)) begin
          set_d   = {set_q[11:0], key_digit};
          state_d = StEntry;
        end
      end
      StCook: begin
        if (stop || door_open) begin
          // Hold prescaler and elapsed; a coincident tick is dropped.
          state_d = StPause;
        end else if (tick) begin
          ps_d = '0;
          el_d = el_inc;
          if (el_inc == set_q) begin
            bc_d    = '0;
            state_d = StDone;
          end
        end else begin
          ps_d = ps_q + PsW'(1);
        end
      end
      StPause: begin
        if (stop) begin
          set_d   = 16'h0000;
          el_d    = 16'h0000;
          ps_d    = '0;
          state_d = StIdle;
        end else if (start && !door_open) begin
          state_d = StCook;
        end
      end
      StDone: begin
        if (stop || door_open) begin
          set_d   = 16'h0000;
          el_d    = 16'h0000;
          ps_d    = '0;
          state_d = StIdle;
        end else if (tick) begin
          ps_d = '0;
          if (bc_q == BcW'(BEEP_SECONDS - 1)) begin
            set_d   = 16'h0000;
            el_d    = 16'h0000;
            state_d = StIdle;
          end else begin
            bc_d = bc_q + BcW'(1);
          end
        end else begin
          ps_d = ps_q + PsW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decode from the state register only (plus the door term on the lamp).
  always_comb begin
    mag_on  = (state_q == StCook);
    beep    = (state_q == StDone);
    busy    = (state_q == StCook) || (state_q == StPause);
    lamp_on = busy || door_open;
    disp    = (state_q == StIdle || state_q == StEntry) ? set_q : el_q;
  end

endmodule

// File: tb/tb_micro_cook_ctrl.sv
// Directed bench for micro_cook_ctrl with TICK_DIV=4, BEEP_SECONDS=2.
module tb_micro_cook_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_valid = 1'b0;
  logic [3:0]  key_digit = 4'd0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        door_open = 1'b0;
  logic        mag_on, lamp_on, beep, busy;
  logic [15:0] disp;

  int n_cmp = 0;
  int n_err = 0;
  int mag_cnt = 0;

  micro_cook_ctrl #(
    .TICK_DIV    (4),
    .BEEP_SECONDS(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_valid(key_valid),
    .key_digit(key_digit),
    .start    (start),
    .stop     (stop),
    .door_open(door_open),
    .mag_on   (mag_on),
    .lamp_on  (lamp_on),
    .beep     (beep),
    .busy     (busy),
    .disp     (disp)
  );

  always #5 clk = ~clk;

  // Magnetron cycles that actually advance the cook (door closed, no stop).
  always @(posedge clk) begin
    if (mag_on && !door_open && !stop) mag_cnt = mag_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    key_valid = 1'b1;
    key_digit = d;
    step(1);
    key_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_beep(input string tag, input int max);
    int n;
    n = 0;
    while (!beep && n < max) begin
      step(1);
      n++;
    end
    check_eq(tag, 16'(beep), 16'h1);
  endtask

  initial begin
    // Reset state
    #12;
    check_eq("rst_mag", 16'(mag_on), 16'h0);
    check_eq("rst_beep", 16'(beep), 16'h0);
    check_eq("rst_busy", 16'(busy), 16'h0);
    check_eq("rst_lamp", 16'(lamp_on), 16'h0);
    check_eq("rst_disp", disp, 16'h0000);
    @(posedge clk); #1;
    rst = 1'b0;
    step(1);

    // 1: 0003 at TICK_DIV=4 -> 12 cook cycles, 8 beep cycles
    press(4'd0); press(4'd0); press(4'd0); press(4'd3);
    check_eq("t1_disp_set", disp, 16'h0003);
    mag_cnt = 0;
    pulse_start();
    check_eq("t1_mag_start", 16'(mag_on), 16'h1);
    check_eq("t1_busy", 16'(busy), 16'h1);
    check_eq("t1_disp_el0", disp, 16'h0000);
    step(11);
    check_eq("t1_disp_c11", disp, 16'h0002);
    check_eq("t1_mag_c11", 16'(mag_on), 16'h1);
    step(1);
    check_eq("t1_disp_c12", disp, 16'h0003);
    check_eq("t1_mag_c12", 16'(mag_on), 16'h0);
    check_eq("t1_beep_c12", 16'(beep), 16'h1);
    check_eq("t1_magcnt", 16'(mag_cnt), 16'd12);
    step(7);
    check_eq("t1_beep_c19", 16'(beep), 16'h1);
    step(1);
    check_eq("t1_beep_end", 16'(beep), 16'h0);
    check_eq("t1_disp_idle", disp, 16'h0000);
    check_eq("t1_busy_idle", 16'(busy), 16'h0);

    // 2: 0105, minute carry 0059 -> 0100
    press(4'd1); press(4'd0); press(4'd5);
    check_eq("t2_disp_set", disp, 16'h0105);
    pulse_start();
    step(236);
    check_eq("t2_disp_59", disp, 16'h0059);
    step(4);
    check_eq("t2_disp_100", disp, 16'h0100);
    step(19);
    check_eq("t2_disp_104", disp, 16'h0104);
    check_eq("t2_mag_104", 16'(mag_on), 16'h1);
    step(1);
    check_eq("t2_disp_105", disp, 16'h0105);
    check_eq("t2_beep", 16'(beep), 16'h1);
    check_eq("t2_mag_done", 16'(mag_on), 16'h0);
    step(8);
    check_eq("t2_disp_idle", disp, 16'h0000);

    // 3: door pause at elapsed 0002, resume, total effective cook = 5 * 4
    press(4'd5);
    mag_cnt = 0;
    pulse_start();
    step(9);
    door_open = 1'b1;
    step(1);
    check_eq("t3_mag_pause", 16'(mag_on), 16'h0);
    check_eq("t3_lamp_pause", 16'(lamp_on), 16'h1);
    check_eq("t3_busy_pause", 16'(busy), 16'h1);
    check_eq("t3_disp_pause", disp, 16'h0002);
    step(19);
    check_eq("t3_disp_frozen", disp, 16'h0002);
    door_open = 1'b0;
    step(1);
    check_eq("t3_still_paused", 16'(mag_on), 16'h0);
    pulse_start();
    check_eq("t3_mag_resume", 16'(mag_on), 16'h1);
    wait_beep("t3_done", 40);
    check_eq("t3_disp_done", disp, 16'h0005);
    check_eq("t3_magcnt", 16'(mag_cnt), 16'd20);
    step(8);
    check_eq("t3_idle", 16'(beep), 16'h0);

    // 4: rejected starts and invalid key
    press(4'd7); press(4'd0);
    pulse_start();
    check_eq("t4_0070_mag", 16'(mag_on), 16'h0);
    check_eq("t4_0070_disp", disp, 16'h0070);
    stop = 1'b1; step(1); stop = 1'b0;
    check_eq("t4_stop_clr", disp, 16'h0000);
    pulse_start();
    check_eq("t4_zero_mag", 16'(mag_on), 16'h0);
    check_eq("t4_zero_busy", 16'(busy), 16'h0);
    press(4'd1); press(4'd2);
    door_open = 1'b1;
    pulse_start();
    check_eq("t4_door_mag", 16'(mag_on), 16'h0);
    check_eq("t4_door_disp", disp, 16'h0012);
    check_eq("t4_door_lamp", 16'(lamp_on), 16'h1);
    door_open = 1'b0;
    press(4'hA);
    check_eq("t4_bad_key", disp, 16'h0012);
    stop = 1'b1; step(1); stop = 1'b0;

    // 5: stop + door + tick together in COOK
    press(4'd2);
    pulse_start();
    step(3);
    stop = 1'b1;
    door_open = 1'b1;
    step(1);
    check_eq("t5_pause_mag", 16'(mag_on), 16'h0);
    check_eq("t5_pause_busy", 16'(busy), 16'h1);
    check_eq("t5_no_inc", disp, 16'h0000);
    door_open = 1'b0;
    step(1);
    stop = 1'b0;
    check_eq("t5_idle_busy", 16'(busy), 16'h0);
    check_eq("t5_idle_disp", disp, 16'h0000);

    // 6: asynchronous reset mid-cook
    press(4'd3);
    pulse_start();
    step(5);
    check_eq("t6_pre_disp", disp, 16'h0001);
    #2 rst = 1'b1;
    #1;
    check_eq("t6_rst_mag", 16'(mag_on), 16'h0);
    check_eq("t6_rst_busy", 16'(busy), 16'h0);
    check_eq("t6_rst_disp", disp, 16'h0000);
    #2 rst = 1'b0;
    step(1);
    pulse_start();
    check_eq("t6_post_mag", 16'(mag_on), 16'h0);
    check_eq("t6_post_busy", 16'(busy), 16'h0);
    press(4'd1);
    check_eq("t6_new_disp", disp, 16'h0001);
    pulse_start();
    check_eq("t6_new_mag", 16'(mag_on), 16'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/micro_cook_ctrl.md
Name: micro_cook_ctrl

Overview:
- Cook-cycle controller for the microwave.
- Captures a 4-digit BCD MM:SS set time from the keypad and counts elapsed time up in BCD, once per second.
- Detects completion by a 16-bit equality compare of elapsed time against set time.
- Drives the magnetron, lamp and beeper, and handles door-interlock pause/resume.

Parameters:
- TICK_DIV, 100000000, clock cycles per one-second tick (>=2).
- BEEP_SECONDS, 3, duration of the beep in DONE, in seconds (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- key_valid  input  1  one-cycle strobe: key_digit is valid.
- key_digit  input  4  BCD digit from keypad.
- start  input  1  start/resume request, level-sampled each cycle.
- stop  input  1  stop/clear request, level-sampled each cycle.
- door_open  input  1  door interlock, 1 = open.
- mag_on  output  1  magnetron enable.
- lamp_on  output  1  cavity lamp.
- beep  output  1  beeper enable.
- busy  output  1  high in COOK or PAUSE.
- disp  output  16  {min_tens, min_units, sec_tens, sec_units} BCD.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values (immediate on rst assertion): state=IDLE, set_time=0000, elapsed=0000, prescaler=0, mag_on=0, lamp_on=0, beep=0, busy=0, disp=0000.
- States: IDLE, ENTRY, COOK, PAUSE, DONE. The state register is the only source for output decode.
  - mag_on = COOK.
  - beep = DONE.
  - busy = COOK|PAUSE.
  - lamp_on = COOK|PAUSE|door_open (door term is combinational).
- disp = set_time in IDLE/ENTRY; disp = elapsed in COOK/PAUSE/DONE.
- Priority within any single cycle: stop > door_open > tick > start > key_valid.
- IDLE/ENTRY:
  - key_valid with key_digit<=9: set_time <= {set_time[11:0], key_digit}; state -> ENTRY.
  - key_digit>9 is ignored.
  - stop: set_time <= 0000; state -> IDLE.
  - start is accepted only if set_time!=0000, set_time[7:4]<=5 and door_open=0. On accept: elapsed <= 0000, prescaler <= 0, state -> COOK.
  - A rejected start causes no change.
- COOK:
  - prescaler increments each cycle. At TICK_DIV-1 it wraps to 0 (the tick) and elapsed increments in BCD.
  - BCD carry chain: sec_units 9->0 carries; sec_tens 5->0 carries; min_units 9->0 carries; min_tens 9->0 wraps (unreachable).
  - If the incremented value equals set_time, the state goes to DONE on the same edge, and prescaler resets to 0.
  - door_open or stop: state -> PAUSE. prescaler and elapsed hold their values; a coincident tick is discarded, with no increment and no prescaler advance.
  - key_valid is ignored.
- PAUSE:
  - prescaler and elapsed are frozen.
  - start with door_open=0: state -> COOK, resuming from the held prescaler value. Total magnetron-on cycles over the run equal exactly set_time seconds × TICK_DIV.
  - stop: set_time <= 0000, elapsed <= 0000, prescaler <= 0; state -> IDLE.
  - key_valid is ignored.
- DONE:
  - prescaler keeps counting seconds. After BEEP_SECONDS ticks: state -> IDLE, set_time <= 0000, elapsed <= 0000.
  - stop or door_open: state -> IDLE immediately, with the same clearing.
  - start and key_valid are ignored.
- Latency:
  - key -> disp update: 1 cycle.
  - start -> mag_on: 1 cycle.
  - Final tick -> mag_on low: same edge that updates elapsed.
- rst mid-operation: all outputs are forced low at once, asynchronously and independent of clk. There is no resume after reset.

Test Plan:
1. TICK_DIV=4, BEEP_SECONDS=2. Keys 0,0,0,3 then start -> mag_on=1 next cycle. elapsed=0003 at cycle 12 with mag_on=0 and beep=1 on the same edge. beep stays high 8 cycles, then IDLE with disp=0000.
2. Keys 1,0,5 -> disp=0105. Start -> disp steps 0059->0100 on one tick; DONE at exactly 0105.
3. During COOK at elapsed=0002, assert door_open for 20 cycles -> PAUSE: mag_on=0, lamp_on=1, elapsed frozen. Close the door and start -> resumes. Total mag_on cycles = set_time×4.
4. Rejected starts, each leaving state and disp unchanged:
   - set 0070 then start -> rejected, stays ENTRY.
   - set 0000 then start -> rejected.
   - valid time with door_open=1 then start -> rejected.
   - key_digit=0xA -> ignored.
5. Simultaneous events:
   - stop, door_open and tick in the same COOK cycle -> PAUSE, elapsed not incremented.
   - A following stop -> IDLE, disp=0000.
6. Assert rst between clock edges during COOK -> mag_on, busy and disp go to 0 before the next clk edge. After release the block is in IDLE and start is ignored until a new time is entered.
